// File: rtl/hcms29xx_ctrl.sv
// Serial controller for a daisy-chain of HCMS-29xx dot-matrix displays: device bring-up,
// framed dot/control transfers over valid/ready, divided display clock and BLANK PWM.
module hcms29xx_ctrl #(
    parameter int          N_UNITS    = 2,
    parameter int          UNIT_W     = 20,
    parameter int          UNIT_H     = 8,
    parameter int          CLK_DIV    = 4,
    parameter int          RST_CYCLES = 32,
    parameter logic [7:0]  CMD_INIT   = 8'h7F,
    parameter int          PWM_BITS   = 6,
    localparam int         FRAME_BITS = N_UNITS * UNIT_W * UNIT_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] frame_data,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic [7:0]            cmd_word,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [PWM_BITS-1:0]   duty,
    output logic                  busy,
    output logic                  dev_rst_n,
    output logic                  dev_clk,
    output logic                  dev_dout,
    output logic                  dev_rs,
    output logic                  dev_ce_n,
    output logic                  dev_blank
);

    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);
    localparam int DIV_CNT_W = $clog2(CLK_DIV + 1);
    localparam int RST_CNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] CMD_LEN   = BIT_CNT_W'(8);
    localparam logic [DIV_CNT_W-1:0] DIV_LAST  = DIV_CNT_W'(CLK_DIV - 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RST_CYCLES - 1);

    // Bring-up states are numbered below S_IDLE so BLANK forcing is a single compare.
    localparam logic [3:0] S_RST       = 4'd0;
    localparam logic [3:0] S_CLR_SETUP = 4'd1;
    localparam logic [3:0] S_CLR_SHIFT = 4'd2;
    localparam logic [3:0] S_CLR_LATCH = 4'd3;
    localparam logic [3:0] S_INI_SETUP = 4'd4;
    localparam logic [3:0] S_INI_SHIFT = 4'd5;
    localparam logic [3:0] S_INI_LATCH = 4'd6;
    localparam logic [3:0] S_IDLE      = 4'd7;
    localparam logic [3:0] S_SETUP     = 4'd8;
    localparam logic [3:0] S_SHIFT     = 4'd9;
    localparam logic [3:0] S_LATCH     = 4'd10;

    logic [3:0]            state_q,     state_d;
    logic [RST_CNT_W-1:0]  rst_cnt_q,   rst_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [BIT_CNT_W-1:0]  len_q,       len_d;
    logic [DIV_CNT_W-1:0]  div_cnt_q,   div_cnt_d;
    logic                  half_q,      half_d;
    logic                  rs_type_q,   rs_type_d;
    logic [FRAME_BITS-1:0] shreg_q,     shreg_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q,   pwm_cnt_d;
    logic [PWM_BITS-1:0]   duty_r_q,    duty_r_d;
    logic                  dev_rst_n_q, dev_rst_n_d;
    logic                  dev_clk_q,   dev_clk_d;
    logic                  dev_dout_q,  dev_dout_d;
    logic                  dev_rs_q,    dev_rs_d;
    logic                  dev_ce_n_q,  dev_ce_n_d;
    logic                  dev_blank_q, dev_blank_d;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        div_cnt_d   = div_cnt_q;
        half_d      = half_q;
        rs_type_d   = rs_type_q;
        shreg_d     = shreg_q;
        dev_rst_n_d = dev_rst_n_q;
        dev_clk_d   = dev_clk_q;
        dev_dout_d  = dev_dout_q;
        dev_rs_d    = dev_rs_q;
        dev_ce_n_d  = dev_ce_n_q;

        case (state_q)
            S_RST: begin
                dev_rst_n_d = 1'b0;
                if (rst_cnt_q == RST_LAST) begin
                    dev_rst_n_d = 1'b1;
                    rst_cnt_d   = '0;
                    shreg_d     = '0;
                    rs_type_d   = 1'b0;
                    len_d       = FRAME_LEN;
                    state_d     = S_CLR_SETUP;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end

            // A command wins over a simultaneous frame offer.
            S_IDLE: begin
                if (cmd_valid) begin
                    shreg_d                   = '0;
                    shreg_d[FRAME_BITS-1 -: 8] = cmd_word;
                    rs_type_d                 = 1'b1;
                    len_d                     = CMD_LEN;
                    state_d                   = S_SETUP;
                end else if (frame_valid) begin
                    shreg_d   = frame_data;
                    rs_type_d = 1'b0;
                    len_d     = FRAME_LEN;
                    state_d   = S_SETUP;
                end
            end

            S_CLR_SETUP, S_INI_SETUP, S_SETUP: begin
                dev_rs_d  = rs_type_q;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                half_d    = 1'b0;
                case (state_q)
                    S_CLR_SETUP: state_d = S_CLR_SHIFT;
                    S_INI_SETUP: state_d = S_INI_SHIFT;
                    default:     state_d = S_SHIFT;
                endcase
            end

            // Each bit period: CLK_DIV clk low (data launched at its start), CLK_DIV clk high.
            S_CLR_SHIFT, S_INI_SHIFT, S_SHIFT: begin
                if (bit_cnt_q == len_q) begin
                    dev_ce_n_d = 1'b1;
                    dev_clk_d  = 1'b0;
                    div_cnt_d  = '0;
                    half_d     = 1'b0;
                    case (state_q)
                        S_CLR_SHIFT: state_d = S_CLR_LATCH;
                        S_INI_SHIFT: state_d = S_INI_LATCH;
                        default:     state_d = S_LATCH;
                    endcase
                end else begin
                    dev_ce_n_d = 1'b0;
                    dev_clk_d  = half_q;
                    if (!half_q && div_cnt_q == '0) begin
                        dev_dout_d = shreg_q[FRAME_BITS-1];
                        shreg_d    = shreg_q << 1;
                    end
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        half_d    = !half_q;
                        if (half_q) begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
                    end
                end
            end

            S_CLR_LATCH, S_INI_LATCH, S_LATCH: begin
                dev_ce_n_d = 1'b1;
                dev_clk_d  = 1'b0;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (half_q) begin
                        half_d   = 1'b0;
                        dev_rs_d = 1'b0;
                        if (state_q == S_CLR_LATCH) begin
                            shreg_d                    = '0;
                            shreg_d[FRAME_BITS-1 -: 8] = CMD_INIT;
                            rs_type_d                  = 1'b1;
                            len_d                      = CMD_LEN;
                            state_d                    = S_INI_SETUP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        half_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
                end
            end

            default: state_d = S_RST;
        endcase
    end

    // Free-running PWM; a new duty only takes effect at the start of a period.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        duty_r_d    = (pwm_cnt_q == '1) ? duty : duty_r_q;
        dev_blank_d = (state_q < S_IDLE) ? 1'b1 : (pwm_cnt_q >= duty_r_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST;
            rst_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            div_cnt_q   <= '0;
            half_q      <= 1'b0;
            rs_type_q   <= 1'b0;
            shreg_q     <= '0;
            pwm_cnt_q   <= '0;
            duty_r_q    <= '0;
            dev_rst_n_q <= 1'b0;
            dev_clk_q   <= 1'b0;
            dev_dout_q  <= 1'b0;
            dev_rs_q    <= 1'b0;
            dev_ce_n_q  <= 1'b1;
            dev_blank_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            div_cnt_q   <= div_cnt_d;
            half_q      <= half_d;
            rs_type_q   <= rs_type_d;
            shreg_q     <= shreg_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_r_q    <= duty_r_d;
            dev_rst_n_q <= dev_rst_n_d;
            dev_clk_q   <= dev_clk_d;
            dev_dout_q  <= dev_dout_d;
            dev_rs_q    <= dev_rs_d;
            dev_ce_n_q  <= dev_ce_n_d;
            dev_blank_q <= dev_blank_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign cmd_ready   = (state_q == S_IDLE);
    assign frame_ready = (state_q == S_IDLE) && !cmd_valid;
    assign dev_rst_n   = dev_rst_n_q;
    assign dev_clk     = dev_clk_q;
    assign dev_dout    = dev_dout_q;
    assign dev_rs      = dev_rs_q;
    assign dev_ce_n    = dev_ce_n_q;
    assign dev_blank   = dev_blank_q;

endmodule

// File: tb/tb_hcms29xx_ctrl.sv
// Directed bench for hcms29xx_ctrl: bring-up, table of transfers, command priority,
// blank PWM and reset during a frame. Outputs are sampled on the falling clock edge.
module tb_hcms29xx_ctrl;

    localparam int NU = 1;
    localparam int UW = 20;
    localparam int UH = 8;
    localparam int CD = 2;
    localparam int RC = 16;
    localparam int PB = 6;
    localparam int FB = NU * UW * UH;
    localparam int BRINGUP = RC + 2 + 2 * CD * (FB + 1) + 2 + 2 * CD * (8 + 1);
    localparam int NV = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FB-1:0] frame_data = '0;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [7:0]    cmd_word = 8'h00;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [PB-1:0] duty = '0;
    logic          busy;
    logic          dev_rst_n, dev_clk, dev_dout, dev_rs, dev_ce_n, dev_blank;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            is_cmd;
        logic [7:0]    cmd;
        logic [FB-1:0] frame;
        bit            scramble;
        logic          exp_rs;
        int            exp_n;
        logic [FB-1:0] exp_bits;
    } vec_t;

    typedef struct {
        logic [FB-1:0] bits;
        int            n;
        int            lat;
        int            ce_len;
        int            dout_bad;
        int            gap;
        logic          rs_pre;
        logic          rs_ok;
        logic          clk_end;
        logic          rs_end;
        logic          rs_idle;
        bit            to;
    } cap_t;

    vec_t vecs[NV];

    hcms29xx_ctrl #(
        .N_UNITS(NU), .UNIT_W(UW), .UNIT_H(UH), .CLK_DIV(CD),
        .RST_CYCLES(RC), .CMD_INIT(8'h7F), .PWM_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .duty(duty), .busy(busy),
        .dev_rst_n(dev_rst_n), .dev_clk(dev_clk), .dev_dout(dev_dout),
        .dev_rs(dev_rs), .dev_ce_n(dev_ce_n), .dev_blank(dev_blank)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [FB-1:0] actual, input logic [FB-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    function automatic logic [FB-1:0] randFrame();
        logic [FB-1:0] v;
        for (int i = 0; i < FB; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    function automatic vec_t mkVec(input bit is_cmd, input logic [7:0] c, input logic [FB-1:0] f,
                                   input bit scr, input logic [FB-1:0] exp_bits);
        vec_t v;
        v.is_cmd   = is_cmd;
        v.cmd      = c;
        v.frame    = f;
        v.scramble = scr;
        v.exp_rs   = is_cmd;
        v.exp_n    = is_cmd ? 8 : FB;
        v.exp_bits = exp_bits;
        return v;
    endfunction

    task automatic checkResetValues(input string tag);
        checkValue({tag, "_rst_n"},       int'(dev_rst_n),   0);
        checkValue({tag, "_dev_clk"},     int'(dev_clk),     0);
        checkValue({tag, "_dout"},        int'(dev_dout),    0);
        checkValue({tag, "_rs"},          int'(dev_rs),      0);
        checkValue({tag, "_ce_n"},        int'(dev_ce_n),    1);
        checkValue({tag, "_blank"},       int'(dev_blank),   1);
        checkValue({tag, "_frame_ready"}, int'(frame_ready), 0);
        checkValue({tag, "_cmd_ready"},   int'(cmd_ready),   0);
        checkValue({tag, "_busy"},        int'(busy),        1);
    endtask

    // Called at a falling edge with rst high for at least one rising edge.
    task automatic bringUpCheck(input string tag);
        int n = 0, rstRise = -1, busyFall = -1, clrN = 0, clrOnes = 0, iniN = 0, blankBad = 0;
        logic [7:0] iniBits = 8'h00;
        logic pc = 1'b0;
        rst = 1'b0;
        while (busyFall < 0 && n < BRINGUP + 200) begin
            @(negedge clk);
            n++;
            if (dev_rst_n && rstRise < 0) rstRise = n;
            if (dev_clk && !pc) begin
                if (dev_rs) begin
                    iniBits = {iniBits[6:0], dev_dout};
                    iniN++;
                end else begin
                    clrN++;
                    if (dev_dout) clrOnes++;
                end
            end
            pc = dev_clk;
            if (busy && !dev_blank) blankBad++;
            if (!busy) busyFall = n;
        end
        checkValue({tag, "_rst_n_rise"}, rstRise, RC);
        checkValue({tag, "_busy_fall"},  busyFall, BRINGUP);
        checkValue({tag, "_clr_pulses"}, clrN, FB);
        checkValue({tag, "_clr_ones"},   clrOnes, 0);
        checkValue({tag, "_ini_pulses"}, iniN, 8);
        checkOutput({tag, "_ini_word"},  FB'(iniBits), FB'(8'h7F));
        checkValue({tag, "_blank_forced"}, blankBad, 0);
    endtask

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic applyStimulus(input bit is_cmd, input logic [7:0] c, input logic [FB-1:0] f);
        int waitCnt = 0;
        if (is_cmd) begin
            cmd_word  = c;
            cmd_valid = 1'b1;
        end else begin
            frame_data  = f;
            frame_valid = 1'b1;
        end
        #1;
        while (!(is_cmd ? cmd_ready : frame_ready) && waitCnt < 3000) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkValue("accept_wait", int'(waitCnt < 3000), 1);
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        frame_valid = 1'b0;
    endtask

    task automatic captureTransfer(input bit scramble, output cap_t r);
        logic pc, pd;
        bit first;
        r.bits = '0; r.n = 0; r.lat = 0; r.ce_len = 0; r.dout_bad = 0; r.gap = 0;
        r.rs_pre = 1'b0; r.rs_ok = 1'b1; r.to = 1'b0;
        @(negedge clk);
        while (dev_ce_n && r.lat < 50) begin
            r.rs_pre = dev_rs;
            if (scramble) frame_data = randFrame();
            @(negedge clk);
            r.lat++;
        end
        if (dev_ce_n) r.to = 1'b1;
        pc = dev_clk;
        pd = dev_dout;
        first = 1'b1;
        while (!dev_ce_n && r.ce_len < 20000) begin
            r.ce_len++;
            if (dev_rs !== r.rs_pre) r.rs_ok = 1'b0;
            if (dev_clk && !pc) begin
                r.bits = {r.bits[FB-2:0], dev_dout};
                r.n++;
            end
            if (dev_dout !== pd && !(dev_clk == 1'b0 && (pc == 1'b1 || first))) r.dout_bad++;
            pc = dev_clk;
            pd = dev_dout;
            first = 1'b0;
            if (scramble) frame_data = randFrame();
            @(negedge clk);
        end
        r.clk_end = dev_clk;
        r.rs_end  = dev_rs;
        while (!cmd_ready && r.gap < 100) begin
            @(negedge clk);
            r.gap++;
        end
        r.rs_idle = dev_rs;
    endtask

    task automatic checkCapture(input string tag, input cap_t r, input logic exp_rs,
                                input int exp_n, input logic [FB-1:0] exp_bits);
        checkValue({tag, "_ce_timeout"},  int'(r.to), 0);
        checkValue({tag, "_ce_fall_lat"}, r.lat, 2);
        checkValue({tag, "_rs_setup"},    int'(r.rs_pre), int'(exp_rs));
        checkValue({tag, "_nbits"},       r.n, exp_n);
        checkOutput({tag, "_bits"},       r.bits, exp_bits);
        checkValue({tag, "_ce_len"},      r.ce_len, 2 * CD * exp_n);
        checkValue({tag, "_rs_stable"},   int'(r.rs_ok), 1);
        checkValue({tag, "_dout_timing"}, r.dout_bad, 0);
        checkValue({tag, "_clk_low_end"}, int'(r.clk_end), 0);
        checkValue({tag, "_rs_latch"},    int'(r.rs_end), int'(exp_rs));
        checkValue({tag, "_ready_gap"},   r.gap, 2 * CD);
        checkValue({tag, "_rs_idle"},     int'(r.rs_idle), 0);
    endtask

    initial begin
        cap_t r;
        int cnt, low, high, rises;
        logic pc;
        logic [FB-1:0] fsim;

        vecs[0] = mkVec(1'b0, 8'h00, 160'h1, 1'b0, 160'h1);
        vecs[1] = mkVec(1'b0, 8'h00, {1'b1, 158'b0, 1'b1}, 1'b0, {1'b1, 158'b0, 1'b1});
        vecs[2] = mkVec(1'b1, 8'h81, '0, 1'b0, 160'h81);
        vecs[3] = mkVec(1'b0, 8'h00, 160'hA5A5_0F0F_DEAD_BEEF_1234_5678_9ABC_DEF0_C3C3_7E81,
                        1'b1, 160'hA5A5_0F0F_DEAD_BEEF_1234_5678_9ABC_DEF0_C3C3_7E81);
        vecs[4] = mkVec(1'b1, 8'h3C, '0, 1'b0, 160'h3C);
        vecs[5] = mkVec(1'b0, 8'h00, {80{2'b01}}, 1'b1, {80{2'b01}});

        // Reset with a frame offered: nothing may be ready.
        frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        frame_valid = 1'b0;
        bringUpCheck("bringup");

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].is_cmd, vecs[i].cmd, vecs[i].frame);
            captureTransfer(vecs[i].scramble, r);
            checkCapture($sformatf("vec%0d", i), r, vecs[i].exp_rs, vecs[i].exp_n, vecs[i].exp_bits);
        end

        // Simultaneous offers: command first, frame at the next idle cycle.
        fsim = 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0003;
        cmd_word    = 8'h81;
        cmd_valid   = 1'b1;
        frame_data  = fsim;
        frame_valid = 1'b1;
        #1;
        checkValue("simul_cmd_ready",   int'(cmd_ready), 1);
        checkValue("simul_frame_ready", int'(frame_ready), 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        captureTransfer(1'b0, r);
        checkCapture("simul_cmd", r, 1'b1, 8, 160'h81);
        checkValue("simul_frame_ready_idle", int'(frame_ready), 1);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        captureTransfer(1'b0, r);
        checkCapture("simul_frame", r, 1'b0, FB, fsim);

        // PWM: duty 16 gives 16 dark-free clocks per 64; a change to 0 waits for the wrap.
        duty = PB'(16);
        cnt = 0;
        while (dev_blank && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        checkValue("pwm_fall_found", int'(cnt < 300), 1);
        low = 0;
        while (!dev_blank && low < 100) begin
            low++;
            @(negedge clk);
        end
        high = 0;
        while (dev_blank && high < 100) begin
            high++;
            @(negedge clk);
        end
        checkValue("pwm16_low", low, 16);
        checkValue("pwm16_high", high, 48);
        low = 0;
        while (!dev_blank && low < 100) begin
            low++;
            if (low == 10) duty = '0;
            @(negedge clk);
        end
        checkValue("pwm_change_midperiod_low", low, 16);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!dev_blank) cnt++;
            @(negedge clk);
        end
        checkValue("pwm0_low_count", cnt, 0);

        // Reset at bit 50 of an all-ones frame.
        applyStimulus(1'b0, 8'h00, '1);
        rises = 0;
        pc = dev_clk;
        cnt = 0;
        while (rises < 50 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (dev_clk && !pc) rises++;
            pc = dev_clk;
        end
        checkValue("midrst_reached_bit50", rises, 50);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("midrst");
        bringUpCheck("rebringup");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
